// File: rtl/code_mem_arb.sv
// code_mem_arb: arbitrates a fetch port and a loader port onto a single
// byte-wide code memory with a shared bidirectional data bus. Fetch has
// priority; the loader is guaranteed service after STARVE_LIMIT losses.
module code_mem_arb #(
  parameter int unsigned MEM_DEPTH    = 8192,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_valid,
  output logic [7:0]  fetch_data,
  output logic        fetch_err,
  input  logic        load_req,
  input  logic        load_we,
  input  logic [15:0] load_addr,
  input  logic [7:0]  load_wdata,
  output logic        load_gnt,
  output logic        load_valid,
  output logic [7:0]  load_rdata,
  output logic        load_err,
  output logic        mem_rw,
  output logic [15:0] mem_addr,
  inout  wire  [7:0]  mem_data
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  // 17 bits so an address of 0xFFFF compares correctly against a depth of 65536
  localparam logic [16:0] DEPTH = 17'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          win_load_q, win_load_d;
  logic          oor_q, oor_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [15:0]   mem_addr_q, mem_addr_d;
  logic          mem_rw_q, mem_rw_d;
  logic          fetch_gnt_q, fetch_gnt_d;
  logic          fetch_valid_q, fetch_valid_d;
  logic [7:0]    fetch_data_q, fetch_data_d;
  logic          fetch_err_q, fetch_err_d;
  logic          load_gnt_q, load_gnt_d;
  logic          load_valid_q, load_valid_d;
  logic [7:0]    load_rdata_q, load_rdata_d;
  logic          load_err_q, load_err_d;
  logic          load_wins_s, fetch_wins_s;
  logic          load_oor_s, fetch_oor_s;

  // Arbitration decision, starvation accounting and next-state computation
  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    win_load_d    = win_load_q;
    oor_d         = oor_q;
    wdata_d       = wdata_q;
    mem_addr_d    = mem_addr_q;
    mem_rw_d      = 1'b1;
    fetch_gnt_d   = 1'b0;
    fetch_valid_d = 1'b0;
    fetch_data_d  = fetch_data_q;
    fetch_err_d   = 1'b0;
    load_gnt_d    = 1'b0;
    load_valid_d  = 1'b0;
    load_rdata_d  = load_rdata_q;
    load_err_d    = 1'b0;
    load_oor_s    = ({1'b0, load_addr} >= DEPTH);
    fetch_oor_s   = ({1'b0, fetch_addr} >= DEPTH);
    load_wins_s   = 1'b0;
    fetch_wins_s  = 1'b0;

    case (state_q)
      IDLE: begin
        load_wins_s  = load_req && (!fetch_req || (starve_q == LIMIT));
        fetch_wins_s = fetch_req && !load_wins_s;
        // Load loses only when it is requesting and fetch takes the slot
        if (!load_req || load_wins_s) begin
          starve_d = '0;
        end else if (starve_q != LIMIT) begin
          starve_d = starve_q + SW'(1);
        end else begin
          starve_d = starve_q;
        end
        if (load_wins_s) begin
          win_load_d = 1'b1;
          mem_addr_d = load_addr;
          wdata_d    = load_wdata;
          oor_d      = load_oor_s;
          load_gnt_d = 1'b1;
          if (load_we) begin
            state_d  = WRITE;
            // Out-of-range writes keep the bus released and the memory reading
            mem_rw_d = load_oor_s;
          end else begin
            state_d  = READ;
          end
        end else if (fetch_wins_s) begin
          win_load_d  = 1'b0;
          mem_addr_d  = fetch_addr;
          oor_d       = fetch_oor_s;
          fetch_gnt_d = 1'b1;
          state_d     = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        state_d = IDLE;
        if (win_load_q) begin
          load_valid_d = 1'b1;
          load_err_d   = oor_q;
          load_rdata_d = oor_q ? 8'h00 : mem_data;
        end else begin
          fetch_valid_d = 1'b1;
          fetch_err_d   = oor_q;
          fetch_data_d  = oor_q ? 8'h00 : mem_data;
        end
      end
      WRITE: begin
        state_d      = IDLE;
        load_valid_d = 1'b1;
        load_err_d   = oor_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset releases the bus immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      starve_q      <= '0;
      win_load_q    <= 1'b0;
      oor_q         <= 1'b0;
      wdata_q       <= 8'h00;
      mem_addr_q    <= 16'h0000;
      mem_rw_q      <= 1'b1;
      fetch_gnt_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= 8'h00;
      fetch_err_q   <= 1'b0;
      load_gnt_q    <= 1'b0;
      load_valid_q  <= 1'b0;
      load_rdata_q  <= 8'h00;
      load_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      win_load_q    <= win_load_d;
      oor_q         <= oor_d;
      wdata_q       <= wdata_d;
      mem_addr_q    <= mem_addr_d;
      mem_rw_q      <= mem_rw_d;
      fetch_gnt_q   <= fetch_gnt_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
      fetch_err_q   <= fetch_err_d;
      load_gnt_q    <= load_gnt_d;
      load_valid_q  <= load_valid_d;
      load_rdata_q  <= load_rdata_d;
      load_err_q    <= load_err_d;
    end
  end

  // The bus enable is the inverse of mem_rw itself, so drive and memory
  // read can never overlap
  assign mem_data    = mem_rw_q ? 8'hzz : wdata_q;
  assign mem_rw      = mem_rw_q;
  assign mem_addr    = mem_addr_q;
  assign fetch_gnt   = fetch_gnt_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_data_q;
  assign fetch_err   = fetch_err_q;
  assign load_gnt    = load_gnt_q;
  assign load_valid  = load_valid_q;
  assign load_rdata  = load_rdata_q;
  assign load_err    = load_err_q;

endmodule

// File: tb/tb_code_mem_arb.sv
// Testbench for code_mem_arb: a byte memory model on the bus plus a
// spec-level reference model (expected contents, latency, grant order).
module tb_code_mem_arb;

  localparam int DEPTH = 8192;
  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_addr = 16'h0000;
  logic        fetch_gnt, fetch_valid, fetch_err;
  logic [7:0]  fetch_data;
  logic        load_req = 1'b0;
  logic        load_we = 1'b0;
  logic [15:0] load_addr = 16'h0000;
  logic [7:0]  load_wdata = 8'h00;
  logic        load_gnt, load_valid, load_err;
  logic [7:0]  load_rdata;
  logic        mem_rw;
  logic [15:0] mem_addr;
  wire  [7:0]  mem_data;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [7:0] exp_load_rdata = 8'h00;

  int n_pass = 0;
  int n_total = 0;
  int bus_err_cnt = 0;
  int overlap_cnt = 0;
  int rw_low_cnt = 0;

  code_mem_arb #(.MEM_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
    .load_req(load_req), .load_we(load_we), .load_addr(load_addr),
    .load_wdata(load_wdata), .load_gnt(load_gnt), .load_valid(load_valid),
    .load_rdata(load_rdata), .load_err(load_err),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  always #5 clock = ~clock;

  // Memory model: drives the bus while mem_rw=1, writes on the edge when 0
  assign mem_data = mem_rw ? mem[mem_addr] : 8'hzz;
  always @(posedge clock) begin
    if (mem_rw === 1'b0) mem[mem_addr] <= mem_data;
  end

  // Continuous bus and pulse-exclusion monitor
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (mem_rw === 1'b1 && mem_data !== mem[mem_addr]) bus_err_cnt += 1;
      if (mem_rw === 1'b1 && $isunknown(mem_data)) bus_err_cnt += 1;
      if ((fetch_gnt && load_gnt) || (fetch_valid && load_valid)) overlap_cnt += 1;
      if (mem_rw === 1'b0) rw_low_cnt += 1;
    end
  end

  // One access from a single requester; called and returns on a negedge
  task automatic access(input bit ld, input bit we, input logic [15:0] a,
                        input logic [7:0] wd, output logic [7:0] rd,
                        output logic er, output int lg, output int lv,
                        output logic rw_g);
    rd = 8'h00; er = 1'b0; lg = 0; lv = 0; rw_g = 1'b1;
    if (ld) begin
      load_req = 1'b1; load_we = we; load_addr = a; load_wdata = wd;
    end else begin
      fetch_req = 1'b1; fetch_addr = a;
    end
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      if ((ld && load_gnt) || (!ld && fetch_gnt)) begin
        lg = i; rw_g = mem_rw;
        fetch_req = 1'b0; load_req = 1'b0;
        fetch_addr = 16'($urandom); load_addr = 16'($urandom);
        load_wdata = 8'($urandom); load_we = 1'($urandom_range(0, 1));
      end
      if ((ld && load_valid) || (!ld && fetch_valid)) begin
        lv = i;
        rd = ld ? load_rdata : fetch_data;
        er = ld ? load_err : fetch_err;
        break;
      end
    end
    fetch_req = 1'b0; load_req = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    #1 reset_n = 1'b0;
    fetch_req = 1'b1; fetch_addr = 16'h0003;
    #1;
    n_total++;
    if ({fetch_gnt, fetch_valid, fetch_err, load_gnt, load_valid, load_err} !== 6'b0)
      $display("FAIL reset_pulses: got %b want 000000",
               {fetch_gnt, fetch_valid, fetch_err, load_gnt, load_valid, load_err});
    else n_pass++;
    n_total++;
    if ({fetch_data, load_rdata} !== 16'h0000)
      $display("FAIL reset_data: got %h want 0000", {fetch_data, load_rdata});
    else n_pass++;
    n_total++;
    if ({mem_rw, mem_addr} !== {1'b1, 16'h0000})
      $display("FAIL reset_bus: got rw=%b addr=%h want rw=1 addr=0000", mem_rw, mem_addr);
    else n_pass++;
    repeat (2) @(negedge clock);
    n_total++;
    if (fetch_gnt !== 1'b0) $display("FAIL reset_no_gnt: got %b want 0", fetch_gnt);
    else n_pass++;
    reset_n = 1'b1;
    @(negedge clock);
    n_total++;
    if (fetch_gnt !== 1'b1) $display("FAIL first_arb_gnt: got %b want 1", fetch_gnt);
    else n_pass++;
    fetch_req = 1'b0;
    @(negedge clock);
    d = ref_mem[3];
    n_total++;
    if ({fetch_valid, fetch_data, fetch_err} !== {1'b1, d, 1'b0})
      $display("FAIL first_arb_data: got v=%b d=%h e=%b want v=1 d=%h e=0",
               fetch_valid, fetch_data, fetch_err, d);
    else n_pass++;
  endtask

  task automatic test_write_then_fetch;
    logic [7:0] rd; logic er, rwg; int lg, lv, rw0;
    rw0 = rw_low_cnt;
    access(1'b1, 1'b1, 16'h1234, 8'hA5, rd, er, lg, lv, rwg);
    ref_mem[16'h1234] = 8'hA5;
    n_total++;
    if ({rwg, er, lg, lv} !== {1'b0, 1'b0, 32'd1, 32'd2})
      $display("FAIL wr_1234: got rw=%b err=%b gnt@%0d valid@%0d want rw=0 err=0 1 2", rwg, er, lg, lv);
    else n_pass++;
    n_total++;
    if (rw_low_cnt - rw0 !== 1) $display("FAIL wr_rw_cycles: got %0d want 1", rw_low_cnt - rw0);
    else n_pass++;
    n_total++;
    if (load_rdata !== exp_load_rdata)
      $display("FAIL wr_rdata_kept: got %h want %h", load_rdata, exp_load_rdata);
    else n_pass++;
    rw0 = rw_low_cnt;
    access(1'b0, 1'b0, 16'h1234, 8'h00, rd, er, lg, lv, rwg);
    n_total++;
    if ({rd, er, lg, lv} !== {8'hA5, 1'b0, 32'd1, 32'd2})
      $display("FAIL rd_1234: got d=%h err=%b gnt@%0d valid@%0d want A5 0 1 2", rd, er, lg, lv);
    else n_pass++;
    n_total++;
    if (rw_low_cnt - rw0 !== 0) $display("FAIL rd_rw_cycles: got %0d want 0", rw_low_cnt - rw0);
    else n_pass++;
  endtask

  task automatic test_starvation;
    int cnt, n;
    bit exp_l;
    cnt = 0; n = 0;
    fetch_req = 1'b1; fetch_addr = 16'h0100;
    load_req = 1'b1; load_we = 1'b0; load_addr = 16'h0200;
    for (int c = 0; c < 80 && n < 12; c++) begin
      @(negedge clock);
      if (fetch_gnt || load_gnt) begin
        exp_l = (cnt == LIMIT);
        cnt = exp_l ? 0 : cnt + 1;
        n_total++;
        if ({load_gnt, fetch_gnt} !== {exp_l, !exp_l})
          $display("FAIL starve_order_%0d: got L=%b F=%b want L=%b F=%b",
                   n, load_gnt, fetch_gnt, exp_l, !exp_l);
        else n_pass++;
        n++;
      end
    end
    fetch_req = 1'b0; load_req = 1'b0;
    n_total++;
    if (n !== 12) $display("FAIL starve_count: got %0d grants want 12", n);
    else n_pass++;
    repeat (2) @(negedge clock);
    exp_load_rdata = ref_mem[16'h0200];
    n_total++;
    if (load_rdata !== exp_load_rdata)
      $display("FAIL starve_load_data: got %h want %h", load_rdata, exp_load_rdata);
    else n_pass++;
  endtask

  task automatic test_out_of_range;
    logic [7:0] rd; logic er, rwg; int lg, lv, rw0;
    rw0 = rw_low_cnt;
    access(1'b1, 1'b1, 16'h2000, 8'h77, rd, er, lg, lv, rwg);
    n_total++;
    if ({rwg, er, lg, lv} !== {1'b1, 1'b1, 32'd1, 32'd2})
      $display("FAIL oor_wr: got rw=%b err=%b gnt@%0d valid@%0d want 1 1 1 2", rwg, er, lg, lv);
    else n_pass++;
    n_total++;
    if (rw_low_cnt - rw0 !== 0) $display("FAIL oor_wr_rw: got %0d want 0", rw_low_cnt - rw0);
    else n_pass++;
    n_total++;
    if ({mem[0], mem[16'h2000]} !== {ref_mem[0], ref_mem[16'h2000]})
      $display("FAIL oor_mem_kept: got %h want %h", {mem[0], mem[16'h2000]},
               {ref_mem[0], ref_mem[16'h2000]});
    else n_pass++;
    access(1'b0, 1'b0, 16'hFFFF, 8'h00, rd, er, lg, lv, rwg);
    n_total++;
    if ({rd, er, lv} !== {8'h00, 1'b1, 32'd2})
      $display("FAIL oor_rd: got d=%h err=%b valid@%0d want 00 1 2", rd, er, lv);
    else n_pass++;
  endtask

  task automatic test_reset_mid_write;
    logic [7:0] rd; logic er, rwg; int lg, lv;
    access(1'b1, 1'b1, 16'h0010, 8'h5A, rd, er, lg, lv, rwg);
    ref_mem[16'h0010] = 8'h5A;
    load_req = 1'b1; load_we = 1'b1; load_addr = 16'h0010; load_wdata = 8'h3C;
    @(negedge clock);
    n_total++;
    if ({load_gnt, mem_rw} !== 2'b10)
      $display("FAIL midwr_in_write: got gnt=%b rw=%b want 1 0", load_gnt, mem_rw);
    else n_pass++;
    #2 reset_n = 1'b0; load_req = 1'b0;
    #1;
    n_total++;
    if ({mem_rw, mem_addr, load_gnt, load_valid, load_rdata} !== {1'b1, 16'h0000, 2'b00, 8'h00})
      $display("FAIL midwr_async: got rw=%b addr=%h g=%b v=%b d=%h want 1 0000 0 0 00",
               mem_rw, mem_addr, load_gnt, load_valid, load_rdata);
    else n_pass++;
    exp_load_rdata = 8'h00;
    @(negedge clock);
    reset_n = 1'b1;
    access(1'b0, 1'b0, 16'h0010, 8'h00, rd, er, lg, lv, rwg);
    n_total++;
    if ({rd, er} !== {8'h5A, 1'b0})
      $display("FAIL midwr_prior_value: got %h err=%b want 5a 0", rd, er);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [7:0] rd, wd, exp_d; logic er, rwg, oor; int lg, lv, rw0;
    logic [15:0] a; bit ld, we;
    for (int t = 0; t < 40; t++) begin
      ld = 1'($urandom_range(0, 1));
      we = ld ? 1'($urandom_range(0, 1)) : 1'b0;
      case ($urandom_range(0, 3))
        0: a = 16'($urandom_range(DEPTH, 65535));
        1: a = 16'($urandom_range(0, DEPTH - 1));
        default: a = 16'($urandom_range(0, 15));
      endcase
      wd = 8'($urandom);
      oor = (int'(a) >= DEPTH);
      exp_d = we ? exp_load_rdata : (oor ? 8'h00 : ref_mem[a]);
      rw0 = rw_low_cnt;
      access(ld, we, a, wd, rd, er, lg, lv, rwg);
      if (we && !oor) ref_mem[a] = wd;
      if (ld && !we) exp_load_rdata = exp_d;
      n_total++;
      if ({rd, er, lg, lv, rw_low_cnt - rw0} !== {exp_d, oor, 32'd1, 32'd2, (we && !oor) ? 32'd1 : 32'd0})
        $display("FAIL rand_%0d: ld=%b we=%b a=%h got d=%h e=%b g@%0d v@%0d rw0s=%0d want d=%h e=%b 1 2 %0d",
                 t, ld, we, a, rd, er, lg, lv, rw_low_cnt - rw0, exp_d, oor, (we && !oor) ? 1 : 0);
      else n_pass++;
    end
  endtask

  task automatic test_bus;
    n_total++;
    if (bus_err_cnt !== 0) $display("FAIL bus_conflict: got %0d events want 0", bus_err_cnt);
    else n_pass++;
    n_total++;
    if (overlap_cnt !== 0) $display("FAIL pulse_overlap: got %0d events want 0", overlap_cnt);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset;
    test_write_then_fetch;
    test_starvation;
    test_out_of_range;
    test_reset_mid_write;
    test_random;
    test_bus;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/code_mem_arb.md
CODE_MEM_ARB -- requirements
Module: code_mem_arb

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 8192: number of valid byte addresses, 0 to MEM_DEPTH-1.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: consecutive lost arbitrations after which load wins.
REQ-003 clock  in  1  single clock; all state changes on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 fetch_req  in  1  fetch read request; held with fetch_addr until fetch_gnt.
REQ-006 fetch_addr  in  16  fetch byte address.
REQ-007 fetch_gnt  out  1  one-cycle pulse; fetch request accepted.
REQ-008 fetch_valid  out  1  one-cycle pulse; fetch_data/fetch_err valid.
REQ-009 fetch_data  out  8  fetch read data, registered.
REQ-010 fetch_err  out  1  out-of-range fetch; qualified by fetch_valid.
REQ-011 load_req  in  1  loader request; held with load_we/addr/wdata until load_gnt.
REQ-012 load_we  in  1  1 = write, 0 = read.
REQ-013 load_addr  in  16  loader byte address.
REQ-014 load_wdata  in  8  loader write data.
REQ-015 load_gnt  out  1  one-cycle pulse; load request accepted.
REQ-016 load_valid  out  1  one-cycle pulse; load read data or write completion.
REQ-017 load_rdata  out  8  loader read data, registered.
REQ-018 load_err  out  1  out-of-range load; qualified by load_valid.
REQ-019 mem_rw  out  1  code memory rw: 1 = read (memory drives bus), 0 = write on clock edge.
REQ-020 mem_addr  out  16  code memory address bus, registered.
REQ-021 mem_data  inout  8  code memory data bus; driven by block only while mem_rw=0.

Function
REQ-022 FSM states SHALL be IDLE, READ and WRITE; READ and WRITE each last exactly one cycle and then return to IDLE.
REQ-023 Requests SHALL be sampled only in IDLE; requests seen in READ or WRITE wait.
REQ-024 Arbitration in IDLE: if only one requester is active, it wins; if both are active, fetch wins unless starve_cnt==STARVE_LIMIT, in which case load wins.
REQ-025 starve_cnt SHALL increment (saturating at STARVE_LIMIT) when load loses, and clear when load wins or load_req=0 in IDLE.
REQ-026 Winner selection at edge E: latch addr/we/wdata, set mem_addr, go to READ (fetch, or load with load_we=0) or WRITE (load with load_we=1).
REQ-027 The winner's gnt SHALL be high for the single cycle after E; the requester may change its inputs from the following cycle.
REQ-028 READ cycle: mem_rw=1, mem_data released; mem_data captured into the winner's data register at the closing edge; valid high the next cycle.
REQ-029 WRITE cycle: mem_rw=0, mem_data driven with latched wdata; memory writes at the closing edge; load_valid high the next cycle, and load_rdata is unchanged.
REQ-030 Latency: request seen at edge E -> gnt in cycle E+1 -> valid in cycle E+2; one access per 2 cycles maximum; a new request may be accepted at the edge ending the valid cycle.
REQ-031 Out-of-range (addr >= MEM_DEPTH): the request is granted and the sequence is the same, but mem_rw stays 1, there is no bus drive and no memory write; data register is loaded with 0x00; err=1 with valid.
REQ-032 The block SHALL drive mem_data only while in WRITE, so there is never a bus overlap with the memory (which drives the bus while mem_rw=1).
REQ-033 mem_rw SHALL be 1 in every state except an in-range WRITE.
REQ-034 gnt/valid pulses for fetch and load SHALL never both be high in the same cycle.

Reset
REQ-035 reset_n=0 SHALL force, immediately and independent of clock, the following values:
- state IDLE;
- mem_rw=1, mem_data high-Z, mem_addr=0x0000;
- all gnt, valid and err outputs = 0;
- fetch_data and load_rdata = 0x00;
- starve_cnt=0.
REQ-036 Reset during WRITE SHALL abort the write: mem_rw goes to 1 before the next edge, so no memory update occurs. The pending request is dropped and must be re-presented after reset.
REQ-037 The first arbitration SHALL occur at the first rising edge with reset_n=1.

Verification
REQ-038 Load write 0x1234<-0xA5, then fetch read 0x1234 -> mem_rw=0 only in the WRITE cycle; fetch_valid two cycles after request with fetch_data=0xA5, fetch_err=0.
REQ-039 fetch_req and load_req held high continuously for 12 accesses with STARVE_LIMIT=4 -> grant order F,F,F,F,L,F,F,F,F,L,...; no gnt overlap.
REQ-040 Load write to 0x2000 (MEM_DEPTH=8192) -> load_valid with load_err=1, mem_rw never 0, memory at 0x0000 unchanged.
REQ-041 reset_n low mid-WRITE to 0x0010 with data 0x3C -> mem_rw=1 and mem_data high-Z asynchronously; subsequent read of 0x0010 returns the prior value.
REQ-042 Bus check throughout all tests: mem_data is never driven by the block while mem_rw=1; no X on mem_data during READ.
